// File: rtl/playfield_scroll_engine.sv
// Multi-layer playfield scroll engine: per-layer vertical/horizontal position counters
// with CPU-written shadow scroll registers and a per-tile attribute latch.
module playfield_scroll_engine #(
  parameter int NUM_LAYERS = 2,
  parameter int VPOS_W     = 9,
  parameter int HPOS_W     = 9,
  parameter int PF_HEIGHT  = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hsync,
  input  logic                         vblank,
  input  logic                         pix_en,
  input  logic [NUM_LAYERS-1:0]        vscr_ld,
  input  logic [NUM_LAYERS-1:0]        hscr_ld,
  input  logic [15:0]                  vbd,
  input  logic [NUM_LAYERS-1:0]        attr_ld,
  input  logic [15:0]                  vrd,
  output logic [NUM_LAYERS*VPOS_W-1:0] pf_v,
  output logic [NUM_LAYERS*HPOS_W-1:0] pf_h,
  output logic [NUM_LAYERS-1:0]        pf_hflip,
  output logic [NUM_LAYERS-1:0]        pf_bank,
  output logic [NUM_LAYERS*6-1:0]      pf_pic,
  output logic [NUM_LAYERS-1:0]        vpend
);

  localparam logic [VPOS_W-1:0] V_LAST = VPOS_W'(PF_HEIGHT - 1);

  logic hsync_q;
  logic vblank_q;
  logic reset_q;
  logic line_tick;
  logic frame_start;
  logic unused_bits;

  // reset_q masks the first cycle after reset so an hsync held high through
  // reset is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      hsync_q  <= hsync;
      vblank_q <= vblank;
    end
    reset_q <= reset;
  end

  assign line_tick   = hsync & ~hsync_q & ~reset_q;
  assign frame_start = ~vblank & vblank_q;
  assign unused_bits = ^{vrd[13:6], vbd};

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    logic [VPOS_W-1:0] vcnt_q, vcnt_d;
    logic [VPOS_W-1:0] vsh_q, vsh_d;
    logic              vpend_q, vpend_d;
    logic [HPOS_W-1:0] hcnt_q, hcnt_d;
    logic [HPOS_W-1:0] hsh_q, hsh_d;
    logic [7:0]        attr_q, attr_d;

    always_comb begin
      vcnt_d  = vcnt_q;
      vsh_d   = vsh_q;
      vpend_d = vpend_q;
      hcnt_d  = hcnt_q;
      hsh_d   = hsh_q;
      attr_d  = attr_q;

      if (vscr_ld[gi] && vblank) begin
        vcnt_d  = vbd[VPOS_W-1:0];
        vpend_d = 1'b0;
      end else if (frame_start) begin
        vcnt_d  = vsh_q;
        vpend_d = 1'b0;
      end else if (line_tick && !vblank && vpend_q) begin
        // Mid-frame split: the pending value replaces this line's increment.
        vcnt_d  = vsh_q;
        vpend_d = 1'b0;
      end else if (line_tick && !vblank) begin
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VPOS_W'(1);
      end

      // A fresh active-display write stays pending even if a reload consumed the old one.
      if (vscr_ld[gi]) begin
        vsh_d = vbd[VPOS_W-1:0];
        if (!vblank) begin
          vpend_d = 1'b1;
        end
      end

      if (line_tick) begin
        hcnt_d = hsh_q;
      end else if (pix_en) begin
        hcnt_d = hcnt_q + HPOS_W'(1);
      end
      if (hscr_ld[gi]) begin
        hsh_d = vbd[HPOS_W-1:0];
      end

      if (attr_ld[gi]) begin
        attr_d = {vrd[15], vrd[14], vrd[5:0]};
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vcnt_q  <= '0;
        vsh_q   <= '0;
        vpend_q <= 1'b0;
        hcnt_q  <= '0;
        hsh_q   <= '0;
        attr_q  <= '0;
      end else begin
        vcnt_q  <= vcnt_d;
        vsh_q   <= vsh_d;
        vpend_q <= vpend_d;
        hcnt_q  <= hcnt_d;
        hsh_q   <= hsh_d;
        attr_q  <= attr_d;
      end
    end

    assign pf_v[gi*VPOS_W +: VPOS_W] = vcnt_q;
    assign pf_h[gi*HPOS_W +: HPOS_W] = hcnt_q;
    assign pf_hflip[gi]              = attr_q[7];
    assign pf_bank[gi]               = attr_q[6];
    assign pf_pic[gi*6 +: 6]         = attr_q[5:0];
    assign vpend[gi]                 = vpend_q;
  end

endmodule

// File: tb/tb_playfield_scroll_engine.sv
// Bench for playfield_scroll_engine: two instances (PF_HEIGHT 262 and 512) driven in
// lockstep, compared every cycle against a behavioural model, plus directed scenarios.
module tb_playfield_scroll_engine;

  localparam int NL = 2;

  logic        clk = 1'b0;
  logic        reset, hsync, vblank, pix_en;
  logic [1:0]  vscr_ld, hscr_ld, attr_ld;
  logic [15:0] vbd, vrd;

  logic [17:0] pf_v_w     [2];
  logic [17:0] pf_h_w     [2];
  logic [1:0]  pf_hflip_w [2];
  logic [1:0]  pf_bank_w  [2];
  logic [11:0] pf_pic_w   [2];
  logic [1:0]  vpend_w    [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  playfield_scroll_engine #(.NUM_LAYERS(2), .VPOS_W(9), .HPOS_W(9), .PF_HEIGHT(262)) u_a (
    .clk(clk), .reset(reset), .hsync(hsync), .vblank(vblank), .pix_en(pix_en),
    .vscr_ld(vscr_ld), .hscr_ld(hscr_ld), .vbd(vbd), .attr_ld(attr_ld), .vrd(vrd),
    .pf_v(pf_v_w[0]), .pf_h(pf_h_w[0]), .pf_hflip(pf_hflip_w[0]), .pf_bank(pf_bank_w[0]),
    .pf_pic(pf_pic_w[0]), .vpend(vpend_w[0])
  );

  playfield_scroll_engine #(.NUM_LAYERS(2), .VPOS_W(9), .HPOS_W(9), .PF_HEIGHT(512)) u_b (
    .clk(clk), .reset(reset), .hsync(hsync), .vblank(vblank), .pix_en(pix_en),
    .vscr_ld(vscr_ld), .hscr_ld(hscr_ld), .vbd(vbd), .attr_ld(attr_ld), .vrd(vrd),
    .pf_v(pf_v_w[1]), .pf_h(pf_h_w[1]), .pf_hflip(pf_hflip_w[1]), .pf_bank(pf_bank_w[1]),
    .pf_pic(pf_pic_w[1]), .vpend(vpend_w[1])
  );

  // Reference model state, [instance][layer], plain integers.
  int height [2] = '{262, 512};
  int m_vcnt [2][2];
  int m_vsh  [2][2];
  int m_vpend[2][2];
  int m_hcnt [2][2];
  int m_hsh  [2][2];
  int m_hflip[2][2];
  int m_bank [2][2];
  int m_pic  [2][2];
  int m_prev_h, m_prev_vb, m_after_rst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick, fs;
    if (reset) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NL; i++) begin
          m_vcnt[k][i] = 0; m_vsh[k][i] = 0; m_vpend[k][i] = 0;
          m_hcnt[k][i] = 0; m_hsh[k][i] = 0;
          m_hflip[k][i] = 0; m_bank[k][i] = 0; m_pic[k][i] = 0;
        end
      m_prev_h = 0; m_prev_vb = 0; m_after_rst = 1;
      return;
    end
    tick = hsync && !m_prev_h && !m_after_rst;
    fs   = !vblank && m_prev_vb;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NL; i++) begin
        if (vscr_ld[i] && vblank) begin
          m_vcnt[k][i] = vbd % 512; m_vpend[k][i] = 0;
        end else if (fs) begin
          m_vcnt[k][i] = m_vsh[k][i]; m_vpend[k][i] = 0;
        end else if (tick && !vblank && m_vpend[k][i] != 0) begin
          m_vcnt[k][i] = m_vsh[k][i]; m_vpend[k][i] = 0;
        end else if (tick && !vblank) begin
          m_vcnt[k][i] = (m_vcnt[k][i] == height[k] - 1) ? 0 : (m_vcnt[k][i] + 1) % 512;
        end
        if (vscr_ld[i]) begin
          m_vsh[k][i] = vbd % 512;
          if (!vblank) m_vpend[k][i] = 1;
        end
        if (tick) m_hcnt[k][i] = m_hsh[k][i];
        else if (pix_en) m_hcnt[k][i] = (m_hcnt[k][i] + 1) % 512;
        if (hscr_ld[i]) m_hsh[k][i] = vbd % 512;
        if (attr_ld[i]) begin
          m_hflip[k][i] = vrd[15]; m_bank[k][i] = vrd[14]; m_pic[k][i] = vrd % 64;
        end
      end
    m_prev_h = hsync; m_prev_vb = vblank; m_after_rst = 0;
  endtask

  task automatic compare_all();
    logic [17:0] ev, eh;
    logic [1:0]  ef, eb, ep;
    logic [11:0] epic;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NL; i++) begin
        ev[i*9 +: 9]  = 9'(m_vcnt[k][i]);
        eh[i*9 +: 9]  = 9'(m_hcnt[k][i]);
        ef[i]         = 1'(m_hflip[k][i]);
        eb[i]         = 1'(m_bank[k][i]);
        ep[i]         = 1'(m_vpend[k][i]);
        epic[i*6 +: 6] = 6'(m_pic[k][i]);
      end
      check_eq($sformatf("pf_v[%0d]", k), 32'(pf_v_w[k]), 32'(ev));
      check_eq($sformatf("pf_h[%0d]", k), 32'(pf_h_w[k]), 32'(eh));
      check_eq($sformatf("hflip[%0d]", k), 32'(pf_hflip_w[k]), 32'(ef));
      check_eq($sformatf("bank[%0d]", k), 32'(pf_bank_w[k]), 32'(eb));
      check_eq($sformatf("pic[%0d]", k), 32'(pf_pic_w[k]), 32'(epic));
      check_eq($sformatf("vpend[%0d]", k), 32'(vpend_w[k]), 32'(ep));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic line_tick_pulse();
    hsync = 1'b1; cyc();
    hsync = 1'b0; cyc();
  endtask

  initial begin
    reset = 1'b1; hsync = 1'b0; vblank = 1'b0; pix_en = 1'b0;
    vscr_ld = '0; hscr_ld = '0; attr_ld = '0; vbd = '0; vrd = '0;
    cyc(); cyc();
    reset = 1'b0;
    check_eq("rst_pf_v", 32'(pf_v_w[1]), 32'h0);

    // T2: write during vblank takes effect at once and survives the frame start
    vblank = 1'b1; cyc();
    vscr_ld = 2'b01; vbd = 16'h00F0; cyc(); vscr_ld = '0;
    check_eq("t2_load", 32'(pf_v_w[1][8:0]), 32'h0F0);
    vblank = 1'b0; cyc();
    check_eq("t2_fs", 32'(pf_v_w[1][8:0]), 32'h0F0);
    repeat (3) line_tick_pulse();
    check_eq("t2_ticks", 32'(pf_v_w[1][8:0]), 32'h0F3);
    $display("T2 done pf_v0=0x%0h", pf_v_w[1][8:0]);

    // T3: wrap at PF_HEIGHT-1, and no counting during vblank
    vblank = 1'b1; cyc();
    vscr_ld = 2'b01; vbd = 16'd261; cyc(); vscr_ld = '0;
    vblank = 1'b0; cyc();
    line_tick_pulse();
    check_eq("t3_wrap262", 32'(pf_v_w[0][8:0]), 32'd0);
    check_eq("t3_nowrap512", 32'(pf_v_w[1][8:0]), 32'd262);
    vblank = 1'b1; cyc();
    line_tick_pulse();
    check_eq("t3_vblank_hold", 32'(pf_v_w[0][8:0]), 32'd0);
    vscr_ld = 2'b01; vbd = 16'd511; cyc(); vscr_ld = '0;
    vblank = 1'b0; cyc();
    line_tick_pulse();
    check_eq("t3_wrap512", 32'(pf_v_w[1][8:0]), 32'd0);
    $display("T3 done");

    // T4: mid-frame split on layer 1
    vblank = 1'b1; vscr_ld = 2'b10; vbd = 16'h0040; cyc(); vscr_ld = '0;
    vblank = 1'b0; cyc();
    vscr_ld = 2'b10; vbd = 16'h0100; cyc(); vscr_ld = '0;
    check_eq("t4_pend", 32'(vpend_w[1][1]), 32'd1);
    check_eq("t4_hold", 32'(pf_v_w[1][17:9]), 32'h040);
    line_tick_pulse();
    check_eq("t4_split", 32'(pf_v_w[1][17:9]), 32'h100);
    check_eq("t4_pend_clr", 32'(vpend_w[1][1]), 32'd0);
    line_tick_pulse();
    check_eq("t4_inc", 32'(pf_v_w[1][17:9]), 32'h101);
    $display("T4 done");

    // T5: horizontal shadow applies only at the next line, then wraps
    hscr_ld = 2'b01; vbd = 16'h01FE; cyc(); hscr_ld = '0;
    check_eq("t5_unaffected", 32'(pf_h_w[1][8:0]), 32'h000);
    line_tick_pulse();
    check_eq("t5_load", 32'(pf_h_w[1][8:0]), 32'h1FE);
    pix_en = 1'b1; repeat (3) cyc(); pix_en = 1'b0;
    check_eq("t5_wrap", 32'(pf_h_w[1][8:0]), 32'h001);
    $display("T5 done");

    // T6: attribute latch on layer 1 only
    vrd = 16'hC02A; attr_ld = 2'b10; cyc(); attr_ld = '0;
    check_eq("t6_hflip", 32'(pf_hflip_w[1]), 32'b10);
    check_eq("t6_bank", 32'(pf_bank_w[1]), 32'b10);
    check_eq("t6_pic", 32'(pf_pic_w[1]), 32'hA80);
    $display("T6 done");

    // T1: reset mid-frame with a pending write and hsync held high
    vblank = 1'b1; vscr_ld = 2'b01; vbd = 16'h0123; cyc(); vscr_ld = '0;
    vblank = 1'b0; cyc();
    vscr_ld = 2'b01; vbd = 16'h0055; cyc(); vscr_ld = '0;
    check_eq("t1_pre_v", 32'(pf_v_w[1][8:0]), 32'h123);
    check_eq("t1_pre_pend", 32'(vpend_w[1][0]), 32'd1);
    reset = 1'b1; hsync = 1'b1; cyc();
    reset = 1'b0;
    check_eq("t1_v_zero", 32'(pf_v_w[1]), 32'h0);
    check_eq("t1_pend_zero", 32'(vpend_w[1]), 32'h0);
    check_eq("t1_attr_zero", 32'({pf_hflip_w[1], pf_bank_w[1], pf_pic_w[1]}), 32'h0);
    repeat (3) cyc();
    check_eq("t1_no_tick_h", 32'(pf_h_w[1]), 32'h0);
    hsync = 1'b0;
    $display("T1 done");

    // Randomised traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset   = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 5) == 0) hsync = ~hsync;
      if ($urandom_range(0, 79) == 0) vblank = ~vblank;
      pix_en  = 1'($urandom_range(0, 1));
      vscr_ld = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hscr_ld = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      attr_ld = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      vbd     = 16'($urandom);
      vrd     = 16'($urandom);
      cyc();
    end
    $display("random phase done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
